dcache_sram: RTL and testbench

// - Single-port, synchronous-read RAM macro model for the non-blocking L1 dcache.
// - Used for the data, tag and packed valid/dirty arrays, one instance per way or per array.
// - Byte-granular write enables and an optional per-word user field.
// - Asynchronous reset clears the array, so valid/dirty bits read 0 after reset.

---
 rtl/dcache_sram_pkg.sv | 14 +
 rtl/dcache_sram_lane.sv | 38 +++
 rtl/dcache_sram.sv | 93 +++++++++
 tb/tb_dcache_sram.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_sram_pkg.sv
// dcache_sram_pkg: sizing helpers shared by the dcache RAM model and its lanes.
// Provides address-width and lane-count derivation functions.
package dcache_sram_pkg;

   // Address width never drops below one bit, even for a single-word array.
   function automatic int f_addr_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int f_ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/dcache_sram_lane.sv
// dcache_sram_lane: one storage column of W bits x DEPTH words, async cleared.
// Ports: clk_i, rst_i, we_i (already qualified), addr_i, wdata_i, rdata_o (comb).
module dcache_sram_lane
   import dcache_sram_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [W-1:0]  wdata_i,
   output logic [W-1:0]  rdata_o
);

   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] w_idx;

   // Out-of-range addresses are folded onto word 0 so the array is never
   // indexed past its end; the top masks such reads and drops such writes.
   assign w_idx   = ({1'b0, addr_i} < LP_DEPTH) ? addr_i : '0;
   assign rdata_o = r_mem[w_idx];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (we_i) begin
         r_mem[w_idx] <= wdata_i;
      end
   end

endmodule

// File: rtl/dcache_sram.sv
// dcache_sram: single-port sync-read RAM model with byte enables and user field.
// Ports: clk_i, rst_i, req_i, we_i, addr_i, wuser_i, wdata_i, be_i, ruser_o, rdata_o.
module dcache_sram
   import dcache_sram_pkg::*;
#(
   parameter int   DATA_WIDTH = 64,
   parameter int   USER_WIDTH = 1,
   parameter int   USER_EN    = 0,
   parameter int   BYTE_WIDTH = 8,
   parameter int   NUM_WORDS  = 1024,
   localparam int  AW = f_addr_w(NUM_WORDS),
   localparam int  BW = f_ceil_div(DATA_WIDTH, BYTE_WIDTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [AW-1:0]         addr_i,
   input  logic [USER_WIDTH-1:0] wuser_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [BW-1:0]         be_i,
   output logic [USER_WIDTH-1:0] ruser_o,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   localparam logic [AW:0] LP_DEPTH = (AW+1)'(NUM_WORDS);

   logic                  w_in_range;
   logic                  w_wr;
   logic                  w_rd;
   logic [DATA_WIDTH-1:0] w_rdata;
   logic [USER_WIDTH-1:0] w_ruser;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [USER_WIDTH-1:0] r_ruser;

   assign w_in_range = ({1'b0, addr_i} < LP_DEPTH);
   assign w_wr       = req_i & we_i & w_in_range;
   assign w_rd       = req_i & ~we_i;

   for (genvar k = 0; k < BW; k++) begin : g_lane
      // The top lane absorbs the remainder when DATA_WIDTH is not a
      // multiple of BYTE_WIDTH.
      localparam int LW = (k == BW-1) ? (DATA_WIDTH - k*BYTE_WIDTH)
                                      : BYTE_WIDTH;
      dcache_sram_lane #(
         .W     (LW),
         .DEPTH (NUM_WORDS),
         .AW    (AW)
      ) u_lane (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .we_i    (w_wr & be_i[k]),
         .addr_i  (addr_i),
         .wdata_i (wdata_i[k*BYTE_WIDTH +: LW]),
         .rdata_o (w_rdata[k*BYTE_WIDTH +: LW])
      );
   end

   if (USER_EN != 0) begin : g_user
      // Sideband is written whole whenever any data lane is written.
      dcache_sram_lane #(
         .W     (USER_WIDTH),
         .DEPTH (NUM_WORDS),
         .AW    (AW)
      ) u_user (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .we_i    (w_wr & (|be_i)),
         .addr_i  (addr_i),
         .wdata_i (wuser_i),
         .rdata_o (w_ruser)
      );
   end else begin : g_no_user
      logic w_unused_user;
      assign w_unused_user = ^wuser_i;
      assign w_ruser       = '0;
   end

   // Output register only moves on a read; writes and idle cycles hold it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rdata <= '0;
         r_ruser <= '0;
      end else if (w_rd) begin
         r_rdata <= w_in_range ? w_rdata : '0;
         r_ruser <= w_in_range ? w_ruser : '0;
      end
   end

   assign rdata_o = r_rdata;
   assign ruser_o = r_ruser;

endmodule

// File: tb/tb_dcache_sram.sv
// tb_dcache_sram: directed vectors, corner sequences and a scoreboard run.
// Covers 64-bit (user on/off) and 12-bit/6-word partial-lane instances.
module tb_dcache_sram;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // 64-bit instances share stimulus
   logic        req, we;
   logic [9:0]  addr;
   logic [0:0]  wuser;
   logic [63:0] wdata;
   logic [7:0]  be;
   logic [0:0]  ruser_a, ruser_b;
   logic [63:0] rdata_a, rdata_b;

   // 12-bit, 6-word instance
   logic        req12, we12;
   logic [2:0]  addr12;
   logic [0:0]  wuser12;
   logic [11:0] wdata12;
   logic [1:0]  be12;
   logic [0:0]  ruser12;
   logic [11:0] rdata12;

   dcache_sram #(
      .DATA_WIDTH(64), .USER_WIDTH(1), .USER_EN(1),
      .BYTE_WIDTH(8), .NUM_WORDS(1024)
   ) u_a (
      .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we),
      .addr_i(addr), .wuser_i(wuser), .wdata_i(wdata), .be_i(be),
      .ruser_o(ruser_a), .rdata_o(rdata_a)
   );

   dcache_sram #(
      .DATA_WIDTH(64), .USER_WIDTH(1), .USER_EN(0),
      .BYTE_WIDTH(8), .NUM_WORDS(1024)
   ) u_b (
      .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we),
      .addr_i(addr), .wuser_i(wuser), .wdata_i(wdata), .be_i(be),
      .ruser_o(ruser_b), .rdata_o(rdata_b)
   );

   dcache_sram #(
      .DATA_WIDTH(12), .USER_WIDTH(1), .USER_EN(0),
      .BYTE_WIDTH(8), .NUM_WORDS(6)
   ) u_c (
      .clk_i(clk), .rst_i(rst), .req_i(req12), .we_i(we12),
      .addr_i(addr12), .wuser_i(wuser12), .wdata_i(wdata12), .be_i(be12),
      .ruser_o(ruser12), .rdata_o(rdata12)
   );

   typedef struct {
      logic        req;
      logic        we;
      logic [9:0]  addr;
      logic [63:0] wdata;
      logic [7:0]  be;
      logic        wuser;
      logic [63:0] exp_rdata;
      logic        exp_ruser;
   } vec_t;

   vec_t vecs [13];

   logic [63:0] model  [16];
   logic        umodel [16];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drv(input logic r, input logic w, input logic [9:0] a,
                      input logic [63:0] d, input logic [7:0] b,
                      input logic u);
      req = r; we = w; addr = a; wdata = d; be = b; wuser = u;
   endtask

   task automatic drv12(input logic r, input logic w, input logic [2:0] a,
                        input logic [11:0] d, input logic [1:0] b);
      req12 = r; we12 = w; addr12 = a; wdata12 = d; be12 = b;
   endtask

   initial begin
      logic [63:0] exp_r;
      logic        exp_u;

      drv(0, 0, 0, 0, 0, 0);
      drv12(0, 0, 0, 0, 0);
      wuser12 = 1'b0;

      vecs[0]  = '{1, 1, 10'd3,    64'h1122334455667788, 8'hFF, 0,
                   64'h0, 0};
      vecs[1]  = '{1, 1, 10'd3,    64'hAAAAAAAAAAAAAAAA, 8'h0F, 0,
                   64'h0, 0};
      vecs[2]  = '{1, 0, 10'd3,    64'h0, 8'h00, 0,
                   64'h11223344AAAAAAAA, 0};
      vecs[3]  = '{0, 1, 10'd3,    64'hFFFFFFFFFFFFFFFF, 8'hFF, 1,
                   64'h11223344AAAAAAAA, 0};
      vecs[4]  = '{1, 1, 10'd7,    64'h0000000000000055, 8'h01, 1,
                   64'h11223344AAAAAAAA, 0};
      vecs[5]  = '{1, 0, 10'd7,    64'h0, 8'h00, 0,
                   64'h0000000000000055, 1};
      vecs[6]  = '{1, 1, 10'd9,    64'h0123456789ABCDEF, 8'hFF, 0,
                   64'h0000000000000055, 1};
      vecs[7]  = '{1, 0, 10'd9,    64'h0, 8'h00, 0,
                   64'h0123456789ABCDEF, 0};
      vecs[8]  = '{1, 1, 10'd1023, 64'hFEEDFACE00000001, 8'hF0, 1,
                   64'h0123456789ABCDEF, 0};
      vecs[9]  = '{1, 0, 10'd1023, 64'h0, 8'h00, 0,
                   64'hFEEDFACE00000000, 1};
      vecs[10] = '{1, 1, 10'd7,    64'hFFFFFFFFFFFFFFFF, 8'h00, 0,
                   64'hFEEDFACE00000000, 1};
      vecs[11] = '{1, 0, 10'd7,    64'h0, 8'h00, 0,
                   64'h0000000000000055, 1};
      vecs[12] = '{1, 0, 10'd0,    64'h0, 8'h00, 0,
                   64'h0, 0};

      // reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_rdata", rdata_a, 64'h0);
      chk("rst_ruser", 64'(ruser_a), 64'h0);
      chk("rst_rdata12", 64'(rdata12), 64'h0);
      rst = 1'b0;
      @(negedge clk);

      // directed table
      foreach (vecs[i]) begin
         drv(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].be, vecs[i].wuser);
         cyc();
         chk($sformatf("vec%0d_rdata", i), rdata_a, vecs[i].exp_rdata);
         chk($sformatf("vec%0d_ruser", i), 64'(ruser_a),
             64'(vecs[i].exp_ruser));
         chk($sformatf("vec%0d_ruser_off", i), 64'(ruser_b), 64'h0);
      end

      // latency: value appears exactly one edge after the read
      drv(1, 0, 10'd3, 0, 0, 0);
      @(posedge clk);
      #1;
      chk("lat_n1", rdata_a, 64'h11223344AAAAAAAA);

      // reset pulse mid-operation
      @(negedge clk);
      drv(1, 1, 10'd5, 64'hDEADBEEFCAFEF00D, 8'hFF, 1);
      cyc();
      drv(1, 0, 10'd5, 0, 0, 0);
      cyc();
      chk("pre_rst_rd5", rdata_a, 64'hDEADBEEFCAFEF00D);
      chk("pre_rst_ru5", 64'(ruser_a), 64'h1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_rdata", rdata_a, 64'h0);
      chk("async_rst_ruser", 64'(ruser_a), 64'h0);
      cyc();
      chk("rst_hold_rdata", rdata_a, 64'h0);
      rst = 1'b0;
      cyc();
      chk("post_rst_rd5", rdata_a, 64'h0);
      chk("post_rst_ru5", 64'(ruser_a), 64'h0);

      // partial lane, last word, out-of-range on the 12-bit instance
      drv12(1, 1, 3'd2, 12'hFFF, 2'b10);
      cyc();
      drv12(1, 0, 3'd2, 0, 0);
      cyc();
      chk("p12_rd2", 64'(rdata12), 64'hF00);
      drv12(1, 1, 3'd5, 12'hABC, 2'b11);
      cyc();
      drv12(1, 0, 3'd5, 0, 0);
      cyc();
      chk("p12_rd5", 64'(rdata12), 64'hABC);
      drv12(1, 0, 3'd0, 0, 0);
      cyc();
      chk("p12_rd0", 64'(rdata12), 64'h0);
      drv12(1, 1, 3'd7, 12'h123, 2'b11);
      cyc();
      drv12(1, 0, 3'd5, 0, 0);
      cyc();
      chk("p12_rd5_again", 64'(rdata12), 64'hABC);
      drv12(1, 0, 3'd7, 0, 0);
      cyc();
      chk("p12_oor7", 64'(rdata12), 64'h0);
      drv12(1, 0, 3'd2, 0, 0);
      cyc();
      drv12(1, 0, 3'd6, 0, 0);
      cyc();
      chk("p12_oor6", 64'(rdata12), 64'h0);
      drv12(0, 0, 0, 0, 0);

      // scoreboard run on the 64-bit instance (array cleared by reset)
      for (int i = 0; i < 16; i++) begin
         model[i]  = '0;
         umodel[i] = 1'b0;
      end
      exp_r = '0;
      exp_u = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         logic        r, w, u;
         logic [3:0]  a;
         logic [63:0] d;
         logic [7:0]  b;
         r = 1'($urandom_range(0, 3) != 0);
         w = 1'($urandom_range(0, 1));
         a = 4'($urandom_range(0, 15));
         d = {$urandom, $urandom};
         b = 8'($urandom);
         u = 1'($urandom);
         drv(r, w, 10'(a), d, b, u);
         if (r && !w) begin
            exp_r = model[a];
            exp_u = umodel[a];
         end else if (r && w) begin
            for (int k = 0; k < 8; k++) begin
               if (b[k]) model[a][k*8 +: 8] = d[k*8 +: 8];
            end
            if (b != 0) umodel[a] = u;
         end
         cyc();
         chk("rand_rdata", rdata_a, exp_r);
         chk("rand_ruser", 64'(ruser_a), 64'(exp_u));
      end
      drv(0, 0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
